// File: rtl/codec_stream_sequencer.sv
// rtl/codec_stream_sequencer.sv - per-tick ADC read, FIR hand-off and DAC write over NUM_CHANNELS channels
module codec_stream_sequencer #(
  parameter int C_S_AXI_ADDR_WIDTH = 14,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_DIV = 2500,
  parameter int CALC_TIMEOUT = 1023,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADC_BASE = 14'h0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] DAC_BASE = 14'h0000,
  parameter int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          enable,
  input  logic                          bypass,
  input  logic                          clr_status,
  output logic                          calc,
  output logic [CH_W-1:0]               channel,
  output logic [DATA_WIDTH-1:0]         rawData,
  input  logic                          calcDone,
  input  logic [DATA_WIDTH-1:0]         filterData,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] ADC_AXI_ARADDR,
  output logic                          ADC_AXI_ARVALID,
  input  logic                          ADC_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ADC_AXI_RDATA,
  input  logic [1:0]                    ADC_AXI_RRESP,
  input  logic                          ADC_AXI_RVALID,
  output logic                          ADC_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] DAC_AXI_AWADDR,
  output logic                          DAC_AXI_AWVALID,
  input  logic                          DAC_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] DAC_AXI_WDATA,
  output logic [3:0]                    DAC_AXI_WSTRB,
  output logic                          DAC_AXI_WVALID,
  input  logic                          DAC_AXI_WREADY,
  input  logic [1:0]                    DAC_AXI_BRESP,
  input  logic                          DAC_AXI_BVALID,
  output logic                          DAC_AXI_BREADY,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout,
  output logic                          resp_err
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TO_W  = $clog2(CALC_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_CALC, S_WR, S_B} state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [CH_W-1:0]         ch;
  logic [DATA_WIDTH-1:0]   raw;
  logic [TO_W-1:0]         wait_cnt;
  logic                    last_ch;
  logic                    calc_expired;
  logic                    start_wr;
  logic [DATA_WIDTH-1:0]   wr_value;
  logic                    unused_rdata;

  function automatic logic [C_S_AXI_ADDR_WIDTH-1:0] ch_addr(
    input logic [C_S_AXI_ADDR_WIDTH-1:0] base,
    input logic [CH_W-1:0]               c
  );
    return base + (C_S_AXI_ADDR_WIDTH'(c) << 2);
  endfunction

  assign tick          = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign last_ch       = (ch == CH_W'(NUM_CHANNELS - 1));
  assign calc_expired  = (wait_cnt == TO_W'(CALC_TIMEOUT - 1));
  assign channel       = ch;
  assign rawData       = raw;
  assign DAC_AXI_WSTRB = {4{S_AXI_ARESETN}};
  assign unused_rdata  = ^ADC_AXI_RDATA;

  always_comb begin
    wr_value = raw;
    start_wr = 1'b0;
    if (state == S_R) begin
      wr_value = ADC_AXI_RDATA[DATA_WIDTH-1:0];
      start_wr = ADC_AXI_RVALID && bypass;
    end else if (state == S_CALC) begin
      if (calcDone) wr_value = filterData;
      start_wr = calcDone || calc_expired;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state           <= S_IDLE;
      ch              <= '0;
      raw             <= '0;
      wait_cnt        <= '0;
      calc            <= 1'b0;
      ADC_AXI_ARADDR  <= '0;
      ADC_AXI_ARVALID <= 1'b0;
      ADC_AXI_RREADY  <= 1'b0;
      DAC_AXI_AWADDR  <= '0;
      DAC_AXI_AWVALID <= 1'b0;
      DAC_AXI_WDATA   <= '0;
      DAC_AXI_WVALID  <= 1'b0;
      DAC_AXI_BREADY  <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      timeout         <= 1'b0;
      resp_err        <= 1'b0;
    end else begin
      calc <= 1'b0;
      // clear first so a same-cycle set below takes priority
      if (clr_status) begin
        overrun  <= 1'b0;
        timeout  <= 1'b0;
        resp_err <= 1'b0;
      end
      if (tick && state != S_IDLE) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick && enable) begin
            ch              <= '0;
            busy            <= 1'b1;
            ADC_AXI_ARADDR  <= ADC_BASE;
            ADC_AXI_ARVALID <= 1'b1;
            state           <= S_AR;
          end
        end
        S_AR: begin
          if (ADC_AXI_ARREADY) begin
            ADC_AXI_ARVALID <= 1'b0;
            ADC_AXI_RREADY  <= 1'b1;
            state           <= S_R;
          end
        end
        S_R: begin
          if (ADC_AXI_RVALID) begin
            ADC_AXI_RREADY <= 1'b0;
            raw            <= ADC_AXI_RDATA[DATA_WIDTH-1:0];
            if (ADC_AXI_RRESP != 2'b00) resp_err <= 1'b1;
            if (!bypass) begin
              calc     <= 1'b1;
              wait_cnt <= '0;
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!start_wr) wait_cnt <= wait_cnt + 1'b1;
          // FIR never answered: fall back to the raw sample
          if (!calcDone && calc_expired) timeout <= 1'b1;
        end
        S_WR: begin
          if (DAC_AXI_AWREADY) DAC_AXI_AWVALID <= 1'b0;
          if (DAC_AXI_WREADY) DAC_AXI_WVALID <= 1'b0;
          if ((!DAC_AXI_AWVALID || DAC_AXI_AWREADY) && (!DAC_AXI_WVALID || DAC_AXI_WREADY)) begin
            DAC_AXI_BREADY <= 1'b1;
            state          <= S_B;
          end
        end
        S_B: begin
          if (DAC_AXI_BVALID) begin
            DAC_AXI_BREADY <= 1'b0;
            if (DAC_AXI_BRESP != 2'b00) resp_err <= 1'b1;
            if (last_ch) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              ch              <= ch + 1'b1;
              ADC_AXI_ARADDR  <= ch_addr(ADC_BASE, ch + 1'b1);
              ADC_AXI_ARVALID <= 1'b1;
              state           <= S_AR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (start_wr) begin
        DAC_AXI_AWADDR  <= ch_addr(DAC_BASE, ch);
        DAC_AXI_AWVALID <= 1'b1;
        DAC_AXI_WDATA   <= C_S_AXI_DATA_WIDTH'(wr_value);
        DAC_AXI_WVALID  <= 1'b1;
        state           <= S_WR;
      end
    end
  end

endmodule

// File: tb/tb_codec_stream_sequencer.sv
// tb/tb_codec_stream_sequencer.sv - scoreboard bench with ADC/DAC slave and FIR models
module tb_codec_stream_sequencer;
  localparam int AW = 14, DW = 32, SW = 16, NCH = 2, DIV = 64, TO = 15;
  localparam logic [13:0] ADC_B = 14'h0040;
  localparam logic [13:0] DAC_B = 14'h0100;

  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 0, bypass = 0, clr_status = 0;
  logic calc; logic [0:0] channel; logic [SW-1:0] rawData;
  logic calcDone = 0; logic [SW-1:0] filterData = '0;
  logic [AW-1:0] ARADDR; logic ARVALID, ARREADY = 0;
  logic [DW-1:0] RDATA = '0; logic [1:0] RRESP = '0; logic RVALID = 0, RREADY;
  logic [AW-1:0] AWADDR; logic AWVALID, AWREADY = 0;
  logic [DW-1:0] WDATA; logic [3:0] WSTRB; logic WVALID, WREADY = 0;
  logic [1:0] BRESP = '0; logic BVALID = 0, BREADY;
  logic busy, overrun, timeout, resp_err;

  codec_stream_sequencer #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .DATA_WIDTH(SW),
    .NUM_CHANNELS(NCH), .SAMPLE_DIV(DIV), .CALC_TIMEOUT(TO),
    .ADC_BASE(ADC_B), .DAC_BASE(DAC_B)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .enable(enable), .bypass(bypass),
    .clr_status(clr_status), .calc(calc), .channel(channel), .rawData(rawData),
    .calcDone(calcDone), .filterData(filterData),
    .ADC_AXI_ARADDR(ARADDR), .ADC_AXI_ARVALID(ARVALID), .ADC_AXI_ARREADY(ARREADY),
    .ADC_AXI_RDATA(RDATA), .ADC_AXI_RRESP(RRESP), .ADC_AXI_RVALID(RVALID), .ADC_AXI_RREADY(RREADY),
    .DAC_AXI_AWADDR(AWADDR), .DAC_AXI_AWVALID(AWVALID), .DAC_AXI_AWREADY(AWREADY),
    .DAC_AXI_WDATA(WDATA), .DAC_AXI_WSTRB(WSTRB), .DAC_AXI_WVALID(WVALID), .DAC_AXI_WREADY(WREADY),
    .DAC_AXI_BRESP(BRESP), .DAC_AXI_BVALID(BVALID), .DAC_AXI_BREADY(BREADY),
    .busy(busy), .overrun(overrun), .timeout(timeout), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [45:0] exp_q[$];
  logic [15:0] adc_q[$];

  // ADC read slave: pushes the expected DAC write for every sample it returns
  int ar_delay = 0, exp_ch = 0, rd_ch = 0, fir_on = 1, fir_delay = 3;
  logic [1:0] rresp_val = 0, bresp_val = 0;
  logic [15:0] adc_s, exp_d, last_raw;
  always begin
    @(negedge clk);
    if (rst_n && ARVALID) begin
      check_eq("ar_addr", 32'(ARADDR), 32'(ADC_B) + 32'(exp_ch * 4));
      repeat (ar_delay) @(negedge clk);
      check_eq("ar_hold", 32'(ARVALID), 1);
      ARREADY = 1;
      @(negedge clk);
      ARREADY = 0;
      adc_s = (adc_q.size() > 0) ? adc_q.pop_front() : 16'($urandom);
      check_eq("rready", 32'(RREADY), 1);
      RDATA = {16'hA5A5, adc_s}; RRESP = rresp_val; RVALID = 1;
      last_raw = adc_s; rd_ch = exp_ch;
      exp_d = (bypass || !fir_on) ? adc_s : adc_s + 16'd1;
      exp_q.push_back({14'(DAC_B + 14'(exp_ch * 4)), 32'(exp_d)});
      exp_ch = (exp_ch + 1) % NCH;
      @(negedge clk);
      RVALID = 0; RRESP = 0;
    end
  end

  // FIR model: answers rawData+1 fir_delay clocks after calc (0 = same cycle)
  int calc_cnt = 0, calc_cyc = 0;
  always begin
    @(negedge clk);
    if (rst_n && calc) begin
      calc_cnt++; calc_cyc = cyc;
      check_eq("raw_data", 32'(rawData), 32'(last_raw));
      check_eq("calc_ch", 32'(channel), 32'(rd_ch));
      if (fir_on && fir_delay == 0) begin
        filterData = rawData + 16'd1; calcDone = 1;
        @(negedge clk);
        calcDone = 0;
      end else begin
        @(negedge clk);
        check_eq("calc_pulse", 32'(calc), 0);
        if (fir_on) begin
          repeat (fir_delay - 1) @(negedge clk);
          filterData = rawData + 16'd1; calcDone = 1;
          @(negedge clk);
          calcDone = 0;
        end
      end
    end
  end

  // DAC write slave with independent AW/W ready delays
  int aw_delay = 0, w_delay = 0, wr_cnt = 0, n_w, proto_err;
  bit aw_done, w_done, chk_gap = 0;
  logic [13:0] got_a; logic [31:0] got_d; logic [45:0] exp_e;
  always begin
    @(negedge clk);
    if (rst_n && (AWVALID || WVALID)) begin
      check_eq("valid_pair", 32'({AWVALID, WVALID}), 32'h3);
      check_eq("wstrb", 32'(WSTRB), 32'hF);
      if (chk_gap) check_eq("timeout_gap", 32'(cyc - calc_cyc), TO);
      aw_done = 0; w_done = 0; n_w = 0; proto_err = 0;
      while (!(aw_done && w_done) && n_w < 1000) begin
        if (aw_done && AWVALID) proto_err++;
        if (w_done && WVALID) proto_err++;
        if (!aw_done) begin
          if (!AWVALID) proto_err++;
          if (n_w >= aw_delay) begin AWREADY = 1; got_a = AWADDR; aw_done = 1; end
        end
        if (!w_done) begin
          if (!WVALID) proto_err++;
          if (n_w >= w_delay) begin WREADY = 1; got_d = WDATA; w_done = 1; end
        end
        @(negedge clk);
        AWREADY = 0; WREADY = 0; n_w++;
      end
      check_eq("wr_proto", 32'(proto_err), 0);
      check_eq("wr_bound", 32'(n_w < 1000), 1);
      check_eq("valids_low", 32'({AWVALID, WVALID}), 0);
      check_eq("bready", 32'(BREADY), 1);
      BVALID = 1; BRESP = bresp_val;
      @(negedge clk);
      BVALID = 0; BRESP = 0;
      wr_cnt++;
      check_eq("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check_eq("wr_addr", 32'(got_a), 32'(exp_e[45:32]));
        check_eq("wr_data", got_d, exp_e[31:0]);
      end
    end
  end

  task automatic wait_busy(input string tag, input logic val, input int max);
    int n;
    n = 0;
    while (busy !== val && n < max) begin @(negedge clk); n++; end
    check_eq(tag, 32'(busy), 32'(val));
  endtask

  task automatic run_frame(input string tag, input int max_len);
    int w0;
    w0 = wr_cnt;
    enable = 1;
    wait_busy({tag, "_start"}, 1'b1, 3 * DIV);
    enable = 0;
    wait_busy({tag, "_end"}, 1'b0, max_len);
    repeat (3) @(negedge clk);
    check_eq({tag, "_writes"}, 32'(wr_cnt - w0), NCH);
  endtask

  task automatic pulse_clr();
    clr_status = 1;
    @(negedge clk);
    clr_status = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, n;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 32'({busy, calc, ARVALID, RREADY, AWVALID, WVALID, BREADY, overrun, timeout, resp_err}), 0);
    check_eq("rst_addr", 32'({ARADDR, AWADDR}), 0);
    rst_n = 1;

    // nominal FIR path
    adc_q.push_back(16'h1234); adc_q.push_back(16'h5678);
    run_frame("fir", 300);
    check_eq("fir_flags", 32'({overrun, timeout, resp_err}), 0);

    // bypass: no calc, raw sample written
    bypass = 1; c0 = calc_cnt;
    adc_q.push_back(16'hBEEF); adc_q.push_back(16'h0042);
    run_frame("byp", 300);
    check_eq("byp_nocalc", 32'(calc_cnt - c0), 0);
    bypass = 0;

    // calcDone coincident with calc, plus wrap of 0xFFFF+1
    fir_delay = 0;
    adc_q.push_back(16'hFFFF); adc_q.push_back(16'h0001);
    run_frame("coinc", 300);
    fir_delay = 3;

    // FIR silent: timeout fallback
    fir_on = 0; chk_gap = 1;
    run_frame("tmo", 300);
    fir_on = 1; chk_gap = 0;
    repeat (5) @(negedge clk);
    check_eq("tmo_sticky", 32'(timeout), 1);
    pulse_clr();
    check_eq("tmo_clr", 32'(timeout), 0);

    // W before AW, then AW before W
    w_delay = 0; aw_delay = 5;
    run_frame("w_first", 300);
    aw_delay = 0; w_delay = 5;
    run_frame("aw_first", 300);
    w_delay = 0;
    check_eq("order_flags", 32'({overrun, timeout, resp_err}), 0);

    // error responses are flagged but data still flows
    rresp_val = 2'b10;
    run_frame("rresp", 300);
    rresp_val = 0;
    check_eq("rresp_flag", 32'(resp_err), 1);
    pulse_clr();
    bresp_val = 2'b01;
    run_frame("bresp", 300);
    bresp_val = 0;
    check_eq("bresp_flag", 32'(resp_err), 1);
    pulse_clr();
    check_eq("resp_clr", 32'(resp_err), 0);

    // slow ARREADY: ticks during frame set overrun, next frame on following tick
    ar_delay = 200; w0 = wr_cnt; enable = 1;
    wait_busy("ovr_start", 1'b1, 3 * DIV);
    wait_busy("ovr_end", 1'b0, 1000);
    ar_delay = 0;
    check_eq("ovr_flag", 32'(overrun), 1);
    wait_busy("ovr_next", 1'b1, DIV + 2);
    enable = 0;
    wait_busy("ovr_next_end", 1'b0, 300);
    repeat (3) @(negedge clk);
    check_eq("ovr_writes", 32'(wr_cnt - w0), 2 * NCH);
    pulse_clr();
    check_eq("ovr_clr", 32'(overrun), 0);

    // reset while waiting in CALC
    fir_on = 0; enable = 1; c0 = calc_cnt; n = 0;
    while (calc_cnt == c0 && n < 3 * DIV) begin @(negedge clk); n++; end
    check_eq("rst_calc_seen", 32'(calc_cnt - c0), 1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("rst_mid_outs", 32'({busy, calc, ARVALID, RREADY, AWVALID, WVALID, BREADY, overrun, timeout, resp_err}), 0);
    check_eq("rst_mid_data", 32'({channel, rawData, ARADDR}), 0);
    exp_q.delete(); exp_ch = 0; fir_on = 1;
    repeat (2) @(negedge clk);
    rst_n = 1; n = 0; w0 = wr_cnt;
    while (!ARVALID && n < 4 * DIV) begin @(negedge clk); n++; end
    check_eq("rst_first_tick", 32'(n), DIV);
    enable = 0;
    wait_busy("rst_frame_end", 1'b0, 300);
    repeat (3) @(negedge clk);
    check_eq("rst_writes", 32'(wr_cnt - w0), NCH);
    check_eq("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/codec_stream_sequencer.md
Name: codec_stream_sequencer

Overview:
- Parametrised successor to the fixed two-channel ADC/DAC controller. Generates a programmable sample-rate tick.
- On each tick it walks NUM_CHANNELS channels. For each channel:
  - reads one sample from the ADC SPI bridge over an AXI4-Lite read master;
  - hands the sample to the FIR engine through the calc/calcDone handshake, or skips the FIR in bypass mode;
  - writes the result to the DAC SPI bridge over an AXI4-Lite write master.
- Adds a calcDone timeout fallback, sticky overrun/timeout flags and per-channel address striding.

Parameters:
- C_S_AXI_ADDR_WIDTH, 14, AXI address width.
- C_S_AXI_DATA_WIDTH, 32, AXI data width.
- DATA_WIDTH, 16, sample width (must be <= C_S_AXI_DATA_WIDTH).
- NUM_CHANNELS, 2, channels per frame (1..16).
- SAMPLE_DIV, 2500, clocks per frame tick (>= 2).
- CALC_TIMEOUT, 1023, max clocks to wait for calcDone.
- ADC_BASE, 14'h0000, ADC read address for channel 0.
- DAC_BASE, 14'h0000, DAC write address for channel 0.
- CH_W, $clog2(NUM_CHANNELS) (minimum 1), channel index width.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- enable  in  1  start frames on ticks
- bypass  in  1  skip FIR; DAC gets raw sample
- clr_status  in  1  clears sticky flags
- calc  out  1  one-cycle FIR start pulse
- channel  out  CH_W  channel of current sample
- rawData  out  DATA_WIDTH  sample to FIR
- calcDone  in  1  FIR result valid (pulse)
- filterData  in  DATA_WIDTH  FIR result
- ADC_AXI_ARADDR  out  C_S_AXI_ADDR_WIDTH  read address
- ADC_AXI_ARVALID  out  1  read address valid
- ADC_AXI_ARREADY  in  1  read address ready
- ADC_AXI_RDATA  in  C_S_AXI_DATA_WIDTH  read data
- ADC_AXI_RRESP  in  2  read response
- ADC_AXI_RVALID  in  1  read data valid
- ADC_AXI_RREADY  out  1  read data ready
- DAC_AXI_AWADDR  out  C_S_AXI_ADDR_WIDTH  write address
- DAC_AXI_AWVALID  out  1  write address valid
- DAC_AXI_AWREADY  in  1  write address ready
- DAC_AXI_WDATA  out  C_S_AXI_DATA_WIDTH  write data
- DAC_AXI_WSTRB  out  4  write strobe, constant 4'hF
- DAC_AXI_WVALID  out  1  write data valid
- DAC_AXI_WREADY  in  1  write data ready
- DAC_AXI_BRESP  in  2  write response
- DAC_AXI_BVALID  in  1  write response valid
- DAC_AXI_BREADY  out  1  write response ready
- busy  out  1  frame in progress
- overrun  out  1  sticky: tick arrived while busy
- timeout  out  1  sticky: calcDone timeout occurred
- resp_err  out  1  sticky: nonzero RRESP or BRESP

Behaviour:

Reset:
- While S_AXI_ARESETN=0, all outputs are 0 and the FSM is IDLE.
- Reset mid-transaction abandons the transaction immediately; no completion is required.

Tick:
- Divider counts 0..SAMPLE_DIV-1 continuously from reset.
- tick is asserted when count = SAMPLE_DIV-1; first tick occurs SAMPLE_DIV cycles after reset release.

FSM states: IDLE, AR, R, CALC, WR, B.
- IDLE -> AR when tick && enable. Sets ch=0, busy=1.
- AR: ARVALID=1, ARADDR=ADC_BASE+ch*4. Holds until ARREADY, then -> R.
- R: RREADY=1. On RVALID:
  - latch RDATA[DATA_WIDTH-1:0];
  - -> WR if bypass (sampled here), else -> CALC.
  - calc=1 for exactly the cycle after latching, with rawData and channel valid.
- CALC:
  - Waits for calcDone; result = filterData.
  - A calcDone coincident with calc is accepted.
  - Wait counter resets on entry. If it reaches CALC_TIMEOUT without calcDone: result = raw sample, timeout<=1, -> WR.
- WR:
  - AWVALID and WVALID both rise on entry. AWADDR=DAC_BASE+ch*4.
  - WDATA = result zero-extended to C_S_AXI_DATA_WIDTH.
  - Each VALID drops independently on its own handshake. Order is AW-first, W-first or simultaneous.
  - -> B once both handshakes are done.
- B: BREADY=1. On BVALID:
  - if ch = NUM_CHANNELS-1: -> IDLE, busy=0;
  - else ch+1 -> AR.

Protocol rules:
- VALID never drops before READY.
- Address and data are stable while VALID is high.
- Nonzero RRESP/BRESP sets resp_err; data is still used and the sequence continues.

Status flags:
- tick while FSM != IDLE: overrun<=1; tick dropped; current frame unaffected.
- enable deasserted mid-frame: the frame completes; no new frames start.
- clr_status clears all sticky flags. If a set event occurs in the same cycle, set wins.
- calcDone outside CALC is ignored.

Test Plan:
- NUM_CHANNELS=2, SAMPLE_DIV=64, bypass=0, zero-wait slaves, ADC returns 0x1234/0x5678, FIR returns input+1 after 3 clocks -> DAC writes 0x1235 at DAC_BASE, then 0x5679 at DAC_BASE+4; busy drops; no flags set.
- bypass=1, ADC returns 0xBEEF -> calc never pulses; DAC WDATA=0x0000BEEF.
- FIR never asserts calcDone, CALC_TIMEOUT=15 -> raw sample written 15 clocks after CALC entry; timeout=1 until clr_status.
- DAC WREADY returned 5 clocks before AWREADY (and the reverse order) -> exactly one write per channel; WVALID/AWVALID held until their respective readies.
- ADC ARREADY delayed 200 clocks with SAMPLE_DIV=64 -> overrun=1; frame still completes; next frame starts on the following tick.
- Assert S_AXI_ARESETN=0 while in CALC -> all outputs 0 immediately; after release, first frame begins at tick with ch=0.
